// File: rtl/axi_sram_loader_pkg.sv
// Shared AXI constants and loader state encoding.
// Imported by the SRAM boot-image loader and its bench.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      S_FILL,
      S_AW,
      S_W,
      S_B,
      S_DONE,
      S_ERR
   } ld_state_t;

endpackage

// File: rtl/axi_sram_loader_if.sv
// Byte-stream load port plus AXI4 write channels.
// master = loader side, slave = byte source and SRAM side.
interface axi_sram_loader_if #(
   parameter int unsigned DW = 128,
   parameter int unsigned AW = 32
);

   logic            LD_VALID;
   logic            LD_READY;
   logic [7:0]      LD_DATA;
   logic            LD_LAST;

   logic [AW-1:0]   MEM_AWADDR;
   logic [7:0]      MEM_AWLEN;
   logic [2:0]      MEM_AWSIZE;
   logic [1:0]      MEM_AWBURST;
   logic            MEM_AWVALID;
   logic            MEM_AWREADY;

   logic [DW-1:0]   MEM_WDATA;
   logic [DW/8-1:0] MEM_WSTRB;
   logic            MEM_WLAST;
   logic            MEM_WVALID;
   logic            MEM_WREADY;

   logic [1:0]      MEM_BRESP;
   logic            MEM_BVALID;
   logic            MEM_BREADY;

   modport master (
      input  LD_VALID, LD_DATA, LD_LAST,
      output LD_READY,
      output MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE,
      output MEM_AWBURST, MEM_AWVALID,
      input  MEM_AWREADY,
      output MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
      input  MEM_WREADY,
      input  MEM_BRESP, MEM_BVALID,
      output MEM_BREADY
   );

   modport slave (
      output LD_VALID, LD_DATA, LD_LAST,
      input  LD_READY,
      input  MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE,
      input  MEM_AWBURST, MEM_AWVALID,
      output MEM_AWREADY,
      input  MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
      output MEM_WREADY,
      output MEM_BRESP, MEM_BVALID,
      input  MEM_BREADY
   );

endinterface

// File: rtl/axi_sram_loader_beat_buf.sv
// One burst of packed beats with per-lane written mask.
// Unwritten lanes read as zero data and zero strobe.
module loader_beat_buf #(
   parameter  int unsigned DW        = 128,
   parameter  int unsigned BURST_LEN = 16,
   localparam int unsigned NB        = DW / 8,
   localparam int unsigned LW        = $clog2(NB),
   localparam int unsigned BIW       =
      (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  logic           CLK,
   input  logic           RSTn,
   input  logic           clr,
   input  logic           wr_en,
   input  logic [BIW-1:0] wr_beat,
   input  logic [LW-1:0]  wr_lane,
   input  logic [7:0]     wr_byte,
   input  logic [BIW-1:0] rd_beat,
   output logic [DW-1:0]  rd_data,
   output logic [NB-1:0]  rd_strb
);

   logic [DW-1:0] data_q [BURST_LEN];
   logic [NB-1:0] strb_q [BURST_LEN];

   // Byte writes into the addressed lane; full clear between bursts.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < int'(BURST_LEN); i++) begin
            data_q[i] <= '0;
            strb_q[i] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < int'(BURST_LEN); i++) begin
            data_q[i] <= '0;
            strb_q[i] <= '0;
         end
      end else if (wr_en) begin
         data_q[wr_beat][{wr_lane, 3'b000} +: 8] <= wr_byte;
         strb_q[wr_beat][wr_lane]                <= 1'b1;
      end
   end

   assign rd_data = data_q[rd_beat];
   assign rd_strb = strb_q[rd_beat];

endmodule

// File: rtl/axi_sram_loader.sv
// Boot-image loader: packs a byte stream into AXI INCR
// bursts and holds the core in reset until all are OKAY.
module axi_sram_loader
   import axi_pkg::*;
#(
   parameter int unsigned   DW        = 128,
   parameter int unsigned   AW        = 32,
   parameter int unsigned   BURST_LEN = 16,
   parameter logic [AW-1:0] BASE_ADDR = AW'(32'h8000_0000)
) (
   input  logic              CLK,
   input  logic              RSTn,
   axi_sram_loader_if.master bus,
   output logic              CORE_RSTn,
   output logic              LOAD_DONE,
   output logic              LOAD_ERR
);

   localparam int unsigned NB  = DW / 8;
   localparam int unsigned LW  = $clog2(NB);
   localparam int unsigned BIW =
      (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned CW  = $clog2(BURST_LEN + 1);

   ld_state_t      state_q;
   ld_state_t      state_nx;
   logic           run_q;
   logic [BIW-1:0] beat_q;
   logic [LW-1:0]  lane_q;
   logic [BIW-1:0] wcnt_q;
   logic [CW-1:0]  nbeats_q;
   logic           img_end_q;
   logic [AW-1:0]  ptr_q;

   logic ld_hs;
   logic fill_end;
   logic lane_full;
   logic beat_full;
   logic aw_hs;
   logic w_hs;
   logic w_last;
   logic b_hs;
   logic b_ok;
   logic buf_clr;

   assign ld_hs     = bus.LD_VALID && bus.LD_READY;
   assign lane_full = (lane_q == LW'(NB - 1));
   assign beat_full = (beat_q == BIW'(BURST_LEN - 1));
   assign fill_end  = ld_hs &&
                      (bus.LD_LAST || (lane_full && beat_full));
   assign aw_hs     = bus.MEM_AWVALID && bus.MEM_AWREADY;
   assign w_hs      = bus.MEM_WVALID && bus.MEM_WREADY;
   assign w_last    = (CW'(wcnt_q) == nbeats_q - CW'(1));
   assign b_hs      = bus.MEM_BVALID && bus.MEM_BREADY;
   assign b_ok      = (bus.MEM_BRESP == AXI_RESP_OKAY);
   assign buf_clr   = b_hs && b_ok && !img_end_q;

   // State register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state_q <= S_FILL;
      else       state_q <= state_nx;
   end

   // Next-state: fill, address, data, response, then terminal.
   always_comb begin
      state_nx = state_q;
      unique case (state_q)
         S_FILL: if (fill_end) state_nx = S_AW;
         S_AW:   if (aw_hs) state_nx = S_W;
         S_W:    if (w_hs && w_last) state_nx = S_B;
         S_B: begin
            if (b_hs) begin
               if (!b_ok)          state_nx = S_ERR;
               else if (img_end_q) state_nx = S_DONE;
               else                state_nx = S_FILL;
            end
         end
         S_DONE: state_nx = S_DONE;
         S_ERR:  state_nx = S_ERR;
         default: state_nx = S_FILL;
      endcase
   end

   // Byte/beat packing, W beat counter and address pointer.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         run_q     <= 1'b0;
         beat_q    <= '0;
         lane_q    <= '0;
         wcnt_q    <= '0;
         nbeats_q  <= '0;
         img_end_q <= 1'b0;
         ptr_q     <= BASE_ADDR;
      end else begin
         run_q <= 1'b1;
         if (ld_hs) begin
            if (fill_end) begin
               lane_q    <= '0;
               beat_q    <= '0;
               nbeats_q  <= CW'(beat_q) + CW'(1);
               img_end_q <= bus.LD_LAST;
            end else if (lane_full) begin
               lane_q <= '0;
               beat_q <= beat_q + BIW'(1);
            end else begin
               lane_q <= lane_q + LW'(1);
            end
         end
         if (w_hs) begin
            wcnt_q <= w_last ? '0 : wcnt_q + BIW'(1);
         end
         if (b_hs && b_ok) begin
            ptr_q <= ptr_q + (AW'(nbeats_q) << LW);
         end
      end
   end

   loader_beat_buf #(
      .DW        (DW),
      .BURST_LEN (BURST_LEN)
   ) u_buf (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .clr     (buf_clr),
      .wr_en   (ld_hs),
      .wr_beat (beat_q),
      .wr_lane (lane_q),
      .wr_byte (bus.LD_DATA),
      .rd_beat (wcnt_q),
      .rd_data (bus.MEM_WDATA),
      .rd_strb (bus.MEM_WSTRB)
   );

   assign bus.LD_READY    = run_q && (state_q == S_FILL);
   assign bus.MEM_AWADDR  = ptr_q;
   assign bus.MEM_AWLEN   = 8'(nbeats_q - CW'(1));
   assign bus.MEM_AWSIZE  = 3'(LW);
   assign bus.MEM_AWBURST = AXI_BURST_INCR;
   assign bus.MEM_AWVALID = (state_q == S_AW);
   assign bus.MEM_WLAST   = w_last;
   assign bus.MEM_WVALID  = (state_q == S_W);
   assign bus.MEM_BREADY  = (state_q == S_B);

   assign CORE_RSTn = (state_q == S_DONE);
   assign LOAD_DONE = (state_q == S_DONE);
   assign LOAD_ERR  = (state_q == S_ERR);

endmodule

// File: tb/tb_axi_sram_loader.sv
// Directed bench for axi_sram_loader with an AXI SRAM
// slave model, optional random stalls and error injection.
module tb_axi_sram_loader;
   import axi_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic CLK = 1'b0;
   logic RSTn = 1'b1;
   logic CORE_RSTn;
   logic LOAD_DONE;
   logic LOAD_ERR;

   axi_sram_loader_if #(.DW(128), .AW(32)) bus ();

   axi_sram_loader #(
      .DW        (128),
      .AW        (32),
      .BURST_LEN (16),
      .BASE_ADDR (BASE)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .bus       (bus),
      .CORE_RSTn (CORE_RSTn),
      .LOAD_DONE (LOAD_DONE),
      .LOAD_ERR  (LOAD_ERR)
   );

   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   bit stall     = 1'b0;
   int err_burst = -1;

   logic [31:0]  aw_addr_q [$];
   logic [7:0]   aw_len_q  [$];
   logic [127:0] wd_q      [$];
   logic [15:0]  ws_q      [$];
   logic         wl_q      [$];
   logic [7:0]   img       [$];
   logic [7:0]   sram      [logic [31:0]];

   int wburst, wbeat, b_pending, b_idx, viol;
   bit b_hs_prev, aw_pend, w_pend;
   logic [31:0]  aw_a;
   logic [7:0]   aw_l;
   logic [127:0] w_d;
   logic [15:0]  w_s;
   logic         w_l;

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      aw_addr_q.delete();
      aw_len_q.delete();
      wd_q.delete();
      ws_q.delete();
      wl_q.delete();
      img.delete();
      sram.delete();
      wburst = 0; wbeat = 0; b_pending = 0;
      b_idx = 0; viol = 0;
      b_hs_prev = 0; aw_pend = 0; w_pend = 0;
      bus.MEM_AWREADY = 1'b0;
      bus.MEM_WREADY  = 1'b0;
      bus.MEM_BVALID  = 1'b0;
      bus.MEM_BRESP   = 2'b00;
      bus.LD_VALID    = 1'b0;
      bus.LD_DATA     = 8'h00;
      bus.LD_LAST     = 1'b0;
   endtask

   // SRAM slave: picks ready/valid for the next edge and records
   // the handshakes that edge will complete.
   always @(negedge CLK) begin
      if (RSTn) begin
         if (b_hs_prev) begin
            bus.MEM_BVALID = 1'b0;
            b_hs_prev = 1'b0;
         end
         if (!bus.MEM_BVALID && b_pending > 0 &&
             (!stall || $urandom_range(0, 2) == 0)) begin
            bus.MEM_BVALID = 1'b1;
            bus.MEM_BRESP  = (b_idx == err_burst) ? 2'b10 : 2'b00;
         end
         if (bus.MEM_BVALID && bus.MEM_BREADY) begin
            b_hs_prev = 1'b1;
            b_pending--;
            b_idx++;
         end

         if (aw_pend && !(bus.MEM_AWVALID &&
             bus.MEM_AWADDR == aw_a && bus.MEM_AWLEN == aw_l))
            viol++;
         bus.MEM_AWREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.MEM_AWVALID && bus.MEM_AWREADY) begin
            if (bus.MEM_AWSIZE != 3'd4 ||
                bus.MEM_AWBURST != AXI_BURST_INCR) viol++;
            aw_addr_q.push_back(bus.MEM_AWADDR);
            aw_len_q.push_back(bus.MEM_AWLEN);
         end
         aw_pend = bus.MEM_AWVALID && !bus.MEM_AWREADY;
         aw_a = bus.MEM_AWADDR;
         aw_l = bus.MEM_AWLEN;

         if (w_pend && !(bus.MEM_WVALID &&
             bus.MEM_WDATA == w_d && bus.MEM_WSTRB == w_s &&
             bus.MEM_WLAST == w_l))
            viol++;
         bus.MEM_WREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.MEM_WVALID && bus.MEM_WREADY) begin
            if (aw_addr_q.size() <= wburst) begin
               viol++;
            end else begin
               for (int l = 0; l < 16; l++)
                  if (bus.MEM_WSTRB[l])
                     sram[aw_addr_q[wburst] + 32'(wbeat * 16 + l)] =
                        bus.MEM_WDATA[l*8 +: 8];
            end
            wd_q.push_back(bus.MEM_WDATA);
            ws_q.push_back(bus.MEM_WSTRB);
            wl_q.push_back(bus.MEM_WLAST);
            if (bus.MEM_WLAST) begin
               wburst++;
               wbeat = 0;
               b_pending++;
            end else begin
               wbeat++;
            end
         end
         w_pend = bus.MEM_WVALID && !bus.MEM_WREADY;
         w_d = bus.MEM_WDATA;
         w_s = bus.MEM_WSTRB;
         w_l = bus.MEM_WLAST;
      end
   end

   function automatic logic [7:0] pat(input int kind, input int i);
      case (kind)
         0:       return 8'(i);
         1:       return 8'(8'h10 + i);
         2:       return 8'(i * 7 + 3);
         default: return 8'hA5;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      #1 RSTn = 1'b0;
      reset_model();
      repeat (2) @(negedge CLK);
      #1 RSTn = 1'b1;
      @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] d, input bit last,
                       output bit ok);
      int n = 0;
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = d;
      bus.LD_LAST  = last;
      while (!bus.LD_READY && !LOAD_ERR && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      ok = bus.LD_READY;
      if (ok) @(negedge CLK);
      bus.LD_VALID = 1'b0;
      bus.LD_LAST  = 1'b0;
   endtask

   task automatic stream(input int n, input int kind,
                         input bit with_last, output int acc);
      bit ok;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         send(pat(kind, i), with_last && (i == n - 1), ok);
         if (!ok) break;
         img.push_back(pat(kind, i));
         acc++;
      end
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!LOAD_DONE && !LOAD_ERR && n < 20000) begin
         @(negedge CLK);
         n++;
      end
      chk({tag, "_timeout"}, 128'(n >= 20000), 128'(0));
   endtask

   task automatic chk_sram(input string tag);
      int bad = 0;
      for (int i = 0; i < img.size(); i++) begin
         if (!sram.exists(BASE + 32'(i)))        bad++;
         else if (sram[BASE + 32'(i)] !== img[i]) bad++;
      end
      chk(tag, 128'(bad), 128'(0));
   endtask

   int acc;
   int bad;

   initial begin
      reset_model();
      #2 RSTn = 1'b0;
      #1;
      chk("rst_awvalid", 128'(bus.MEM_AWVALID), 128'(0));
      chk("rst_wvalid", 128'(bus.MEM_WVALID), 128'(0));
      chk("rst_bready", 128'(bus.MEM_BREADY), 128'(0));
      chk("rst_ld_ready", 128'(bus.LD_READY), 128'(0));
      chk("rst_core_rstn", 128'(CORE_RSTn), 128'(0));
      chk("rst_done", 128'(LOAD_DONE), 128'(0));
      chk("rst_err", 128'(LOAD_ERR), 128'(0));
      repeat (2) @(negedge CLK);
      #1 RSTn = 1'b1;
      @(negedge CLK);

      // 512-byte image, two full bursts
      chk("t1_ld_ready_idle", 128'(bus.LD_READY), 128'(1));
      stream(512, 0, 1'b1, acc);
      wait_end("t1");
      chk("t1_acc", 128'(acc), 128'(512));
      chk("t1_aw_cnt", 128'(aw_addr_q.size()), 128'(2));
      chk("t1_aw0", 128'(aw_addr_q[0]), 128'(32'h8000_0000));
      chk("t1_aw1", 128'(aw_addr_q[1]), 128'(32'h8000_0100));
      chk("t1_len0", 128'(aw_len_q[0]), 128'(15));
      chk("t1_len1", 128'(aw_len_q[1]), 128'(15));
      chk("t1_w_cnt", 128'(ws_q.size()), 128'(32));
      bad = 0;
      for (int i = 0; i < ws_q.size(); i++) begin
         if (ws_q[i] !== 16'hFFFF) bad++;
         if (wl_q[i] !== ((i % 16) == 15)) bad++;
      end
      chk("t1_strb_last", 128'(bad), 128'(0));
      chk("t1_done", 128'(LOAD_DONE), 128'(1));
      chk("t1_core_rstn", 128'(CORE_RSTn), 128'(1));
      chk("t1_ld_ready", 128'(bus.LD_READY), 128'(0));
      chk_sram("t1_sram");
      chk("t1_viol", 128'(viol), 128'(0));

      // 20-byte image, partial second beat
      do_reset();
      stream(20, 1, 1'b1, acc);
      wait_end("t2");
      chk("t2_aw_cnt", 128'(aw_addr_q.size()), 128'(1));
      chk("t2_len", 128'(aw_len_q[0]), 128'(1));
      chk("t2_strb0", 128'(ws_q[0]), 128'(16'hFFFF));
      chk("t2_strb1", 128'(ws_q[1]), 128'(16'h000F));
      chk("t2_hi_zero", wd_q[1] >> 32, 128'(0));
      chk("t2_lo", 128'(wd_q[1][31:0]), 128'(32'h2322_2120));
      chk("t2_last0", 128'(wl_q[0]), 128'(0));
      chk("t2_last1", 128'(wl_q[1]), 128'(1));
      chk("t2_done", 128'(LOAD_DONE), 128'(1));

      // single-byte image
      do_reset();
      stream(1, 3, 1'b1, acc);
      wait_end("t3");
      chk("t3_addr", 128'(aw_addr_q[0]), 128'(BASE));
      chk("t3_len", 128'(aw_len_q[0]), 128'(0));
      chk("t3_data", wd_q[0], 128'(8'hA5));
      chk("t3_strb", 128'(ws_q[0]), 128'(16'h0001));
      chk("t3_last", 128'(wl_q[0]), 128'(1));
      chk("t3_core_rstn", 128'(CORE_RSTn), 128'(1));

      // 1000-byte image under random slave stalls
      do_reset();
      stall = 1'b1;
      stream(1000, 2, 1'b1, acc);
      wait_end("t4");
      stall = 1'b0;
      chk("t4_aw_cnt", 128'(aw_addr_q.size()), 128'(4));
      chk("t4_aw3", 128'(aw_addr_q[3]), 128'(32'h8000_0300));
      chk("t4_len3", 128'(aw_len_q[3]), 128'(14));
      chk("t4_w_cnt", 128'(ws_q.size()), 128'(63));
      chk("t4_strb_end", 128'(ws_q[62]), 128'(16'h00FF));
      chk("t4_viol", 128'(viol), 128'(0));
      chk_sram("t4_sram");
      chk("t4_done", 128'(LOAD_DONE), 128'(1));

      // error response on the second of three bursts
      do_reset();
      err_burst = 1;
      stream(600, 0, 1'b1, acc);
      wait_end("t5");
      repeat (20) @(negedge CLK);
      err_burst = -1;
      chk("t5_acc", 128'(acc), 128'(512));
      chk("t5_err", 128'(LOAD_ERR), 128'(1));
      chk("t5_core_rstn", 128'(CORE_RSTn), 128'(0));
      chk("t5_ld_ready", 128'(bus.LD_READY), 128'(0));
      chk("t5_done", 128'(LOAD_DONE), 128'(0));
      chk("t5_aw_cnt", 128'(aw_addr_q.size()), 128'(2));

      // reset dropped in the middle of a W burst
      do_reset();
      stall = 1'b1;
      stream(256, 0, 1'b0, acc);
      bad = 0;
      while (!(bus.MEM_WVALID && wbeat >= 2) && bad < 5000) begin
         @(negedge CLK);
         bad++;
      end
      chk("t6_mid_w", 128'(bus.MEM_WVALID), 128'(1));
      #2 RSTn = 1'b0;
      #1;
      chk("t6_awvalid", 128'(bus.MEM_AWVALID), 128'(0));
      chk("t6_wvalid", 128'(bus.MEM_WVALID), 128'(0));
      chk("t6_bready", 128'(bus.MEM_BREADY), 128'(0));
      chk("t6_ld_ready", 128'(bus.LD_READY), 128'(0));
      chk("t6_core_rstn", 128'(CORE_RSTn), 128'(0));
      stall = 1'b0;
      reset_model();
      repeat (2) @(negedge CLK);
      #1 RSTn = 1'b1;
      @(negedge CLK);
      stream(16, 1, 1'b1, acc);
      wait_end("t6");
      chk("t6_aw_cnt", 128'(aw_addr_q.size()), 128'(1));
      chk("t6_addr", 128'(aw_addr_q[0]), 128'(BASE));
      chk("t6_len", 128'(aw_len_q[0]), 128'(0));
      chk_sram("t6_sram");
      chk("t6_done", 128'(LOAD_DONE), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
